// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the registered (optionally approximate) adder.
//   DEFAULT_WIDTH       : default operand width in bits (legal 2..32)
//   DEFAULT_APPROX_BITS : default count of low-order bits computed with OR
//                         instead of a true add (0 = exact adder)
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_APPROX_BITS = 0;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage : adder_pkg

// File: rtl/adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, chained by the adder top to form the exact
// (upper) ripple-carry part of the sum.
//   a, b  : operand bits
//   cin   : carry from the next lower bit
//   s     : sum bit
//   cout  : carry to the next higher bit
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
// Registered unsigned adder with an optional lower-part-OR approximation.
// The low APPROX_BITS bits are X|Y (with Cin folded into bit 0); the upper
// bits are an exact ripple-carry add whose carry-in is X[K-1]&Y[K-1].
// With APPROX_BITS = 0 the result is the exact X+Y+Cin.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high; clears Sum immediately
//   X, Y  : WIDTH-bit unsigned operands
//   Cin   : carry-in
//   Sum   : WIDTH+1-bit registered result, MSB is the carry-out
// Latency one cycle, a new operand set is accepted every cycle.
// ---------------------------------------------------------------------------
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int APPROX_BITS = DEFAULT_APPROX_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH:0]   Sum
);

    // carry[i] is the carry into bit i of the exact part; carry[WIDTH] is
    // the carry-out, which becomes the result MSB.
    logic [WIDTH:APPROX_BITS] carry;
    logic [WIDTH:0]           sum_next;
    logic [WIDTH:0]           sum_reg;

    generate
        if (APPROX_BITS == 0) begin : g_exact_cin
            assign carry[0] = Cin;
        end else begin : g_lower_or
            // The exact part only sees the top approximate bit's generate
            // term; lower carries are deliberately dropped.
            assign carry[APPROX_BITS] = X[APPROX_BITS-1] & Y[APPROX_BITS-1];

            for (genvar gi = 0; gi < APPROX_BITS; gi++) begin : g_or_bit
                if (gi == 0) begin : g_bit0
                    // Cin has nowhere to ripple, so it is ORed into bit 0.
                    assign sum_next[gi] = X[gi] | Y[gi] | Cin;
                end else begin : g_bitn
                    assign sum_next[gi] = X[gi] | Y[gi];
                end
            end
        end

        for (genvar gi = APPROX_BITS; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (X[gi]),
                .b    (Y[gi]),
                .cin  (carry[gi]),
                .s    (sum_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign sum_next[WIDTH] = carry[WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign Sum = sum_reg;

endmodule : adder

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder
// Drives an exact (default) adder and an APPROX_BITS=3 adder with shared
// operands, checking both against an arithmetic reference every cycle plus
// directed vectors with literal expected values.
// ---------------------------------------------------------------------------
module tb_adder;

    localparam int W = 8;
    localparam int K = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         Cin = 1'b0;
    logic [W:0]   sum_exact;
    logic [W:0]   sum_approx;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_exact  = '0;
    logic [W:0] exp_approx = '0;

    always #5 clock = ~clock;

    adder u_exact (
        .clock (clock),
        .reset (reset),
        .X     (X),
        .Y     (Y),
        .Cin   (Cin),
        .Sum   (sum_exact)
    );

    adder #(.WIDTH(W), .APPROX_BITS(K)) u_approx (
        .clock (clock),
        .reset (reset),
        .X     (X),
        .Y     (Y),
        .Cin   (Cin),
        .Sum   (sum_approx)
    );

    // Reference result from plain integer arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input int k);
        int hi;
        int lo;
        int r;
        if (k == 0) begin
            r = int'(x) + int'(y) + int'(c);
        end else begin
            hi = (int'(x) >> k) + (int'(y) >> k) + ((int'(x) >> (k - 1)) & (int'(y) >> (k - 1)) & 1);
            lo = ((int'(x) | int'(y)) & ((1 << k) - 1)) | int'(c);
            r  = (hi << k) | lo;
        end
        return r[W:0];
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, req, $time);
        end
    endtask

    // Model of the registered outputs: result of the inputs seen at the last
    // rising edge, or zero whenever reset is high.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_exact  <= '0;
            exp_approx <= '0;
        end else begin
            exp_exact  <= ref_sum(X, Y, Cin, 0);
            exp_approx <= ref_sum(X, Y, Cin, K);
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        check("cycle_exact", sum_exact, exp_exact);
        check("cycle_approx", sum_approx, exp_approx);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        X   = x;
        Y   = y;
        Cin = c;
        $display("vector X=0x%02h Y=0x%02h Cin=%0d", x, y, c);
    endtask

    initial begin
        logic [W:0] held;

        // Reset held across edges, then released with zero operands.
        apply(8'h00, 8'h00, 1'b0);
        step();
        step();
        check("reset_exact", sum_exact, 9'h000);
        check("reset_approx", sum_approx, 9'h000);
        reset = 1'b0;
        step();
        check("first_edge_zero", sum_exact, 9'h000);

        // Exact mode vectors.
        apply(8'hFF, 8'h01, 1'b0);
        step();
        check("ff_plus_01", sum_exact, 9'h100);
        apply(8'h11, 8'h11, 1'b0);
        step();
        check("11_plus_11", sum_exact, 9'h022);
        apply(8'hFF, 8'hFF, 1'b1);
        step();
        check("max_sum", sum_exact, 9'h1FF);
        apply(8'hFF, 8'h00, 1'b1);
        step();
        check("ff_plus_cin", sum_exact, 9'h100);
        step();
        check("ff_plus_cin_held", sum_exact, 9'h100);

        // Input glitches between edges must not reach Sum.
        held = sum_exact;
        apply(8'h5A, 8'h33, 1'b0);
        #2;
        check("no_comb_path", sum_exact, held);
        apply(8'h12, 8'h34, 1'b1);
        step();
        check("last_value_wins", sum_exact, 9'h047);

        // Mid-stream reset clears at once and holds through edges.
        apply(8'hFF, 8'h00, 1'b1);
        step();
        check("pre_reset", sum_exact, 9'h100);
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", sum_exact, 9'h000);
        step();
        check("reset_hold_1", sum_exact, 9'h000);
        step();
        check("reset_hold_2", sum_exact, 9'h000);
        reset = 1'b0;
        step();
        check("post_reset_load", sum_exact, 9'h100);

        // Approximate-mode vectors (hand computed).
        apply(8'h0F, 8'h01, 1'b0);
        step();
        check("approx_0f_01", sum_approx, 9'h00F);
        check("exact_0f_01", sum_exact, 9'h010);
        apply(8'h04, 8'h04, 1'b1);
        step();
        // bits[2:0]=100|1=101, carry-in to upper = 1 -> 0x0D
        check("approx_carry_k1", sum_approx, 9'h00D);
        apply(8'hFF, 8'hFF, 1'b0);
        step();
        // upper 0x1F+0x1F+1=0x3F -> 0x1F8 | 0x7 = 0x1FF
        check("approx_max", sum_approx, 9'h1FF);

        // Reference function pinned against literals.
        check("model_exact", ref_sum(8'hFF, 8'h01, 1'b0, 0), 9'h100);
        check("model_approx", ref_sum(8'h0F, 8'h01, 1'b0, K), 9'h00F);

        // Random regression, checked by the per-cycle compare.
        for (int i = 0; i < 1000; i++) begin
            X   = W'($urandom);
            Y   = W'($urandom);
            Cin = 1'($urandom);
            step();
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder
